// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared constants and elaboration helpers for the clock-enable generator
package clk_en_pkg;

    localparam logic ADJ_ADV = 1'b1;
    localparam logic ADJ_RET = 1'b0;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int sam_div, input int sps, input int frame_len);
        return (sam_div >= 2) && (sps >= 2) && (frame_len >= 1);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: wrap counter with enable, sync clear, runtime terminal count and wrap pulse
module mod_counter #(
    parameter int W = 4
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == term);

    // Count up while enabled, return to zero after the terminal count or on clear.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: sample/symbol/frame clock enables with sync realign and symbol-length adjust
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int SAM_DIV   = 4,
    parameter int SPS       = 4,
    parameter int FRAME_LEN = 16,
    parameter int PW        = $clog2(SPS + 1),
    parameter int FW        = clog2_min1(FRAME_LEN)
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          run,
    input  logic          sync,
    input  logic          adj_valid,
    input  logic          adj_dir,
    output logic          sam_clk_en,
    output logic          sym_clk_en,
    output logic          frame_clk_en,
    output logic [PW-1:0] sam_phase,
    output logic [FW-1:0] sym_index,
    output logic          adj_busy
);

    localparam int DW = clog2_min1(SAM_DIV);

    if (!params_ok(SAM_DIV, SPS, FRAME_LEN)) begin : g_bad_params
        $error("clk_en_gen: SAM_DIV>=2, SPS>=2 and FRAME_LEN>=1 are required");
    end

    // fresh marks the first strobe after reset: it emits phase 0 / index 0 without advancing.
    logic          fresh;
    logic          adj_pend;
    logic          adj_act;
    logic          adj_dir_q;
    logic          div_wrap;
    logic          ph_wrap;
    logic          idx_wrap;
    logic          boundary;
    logic [DW-1:0] unused_div_cnt;
    logic [PW-1:0] ph_term;

    assign ph_term  = !adj_act ? PW'(SPS - 1) : (adj_dir_q == ADJ_ADV) ? PW'(SPS - 2) : PW'(SPS);
    assign boundary = div_wrap && (fresh || ph_wrap);
    assign adj_busy = adj_pend || adj_act;

    mod_counter #(.W(DW)) u_div (
        .sys_clk (sys_clk),
        .reset   (reset),
        .en      (run),
        .clr     (sync),
        .term    (DW'(SAM_DIV - 1)),
        .cnt     (unused_div_cnt),
        .wrap    (div_wrap)
    );

    mod_counter #(.W(PW)) u_phase (
        .sys_clk (sys_clk),
        .reset   (reset),
        .en      (div_wrap && !fresh),
        .clr     (sync),
        .term    (ph_term),
        .cnt     (sam_phase),
        .wrap    (ph_wrap)
    );

    mod_counter #(.W(FW)) u_index (
        .sys_clk (sys_clk),
        .reset   (reset),
        .en      (ph_wrap),
        .clr     (sync),
        .term    (FW'(FRAME_LEN - 1)),
        .cnt     (sym_index),
        .wrap    (idx_wrap)
    );

    // Register the strobes; sync forces a full frame-start strobe.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sam_clk_en   <= 1'b0;
            sym_clk_en   <= 1'b0;
            frame_clk_en <= 1'b0;
            fresh        <= 1'b1;
        end else begin
            sam_clk_en   <= sync || div_wrap;
            sym_clk_en   <= sync || boundary;
            frame_clk_en <= sync || (div_wrap && fresh) || idx_wrap;
            fresh        <= fresh && !sync && !div_wrap;
        end
    end

    // Adjust handshake: latch, activate at the next symbol start, retire at that symbol's end.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            adj_pend  <= 1'b0;
            adj_act   <= 1'b0;
            adj_dir_q <= ADJ_RET;
        end else if (sync) begin
            adj_pend  <= 1'b0;
            adj_act   <= 1'b0;
        end else begin
            if (boundary) begin
                adj_act  <= adj_pend;
                adj_pend <= 1'b0;
            end
            if (adj_valid && !adj_busy) begin
                adj_pend  <= 1'b1;
                adj_dir_q <= adj_dir;
            end
        end
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench for clk_en_gen (default and minimum parameter sets)
module tb_clk_en_gen;

    typedef struct packed {
        int         c;
        logic       sym;
        logic       frm;
        logic [2:0] ph;
        logic [3:0] idx;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0, sync = 1'b0, adj_valid = 1'b0, adj_dir = 1'b0;
    logic       run2 = 1'b0, sync2 = 1'b0, adj_valid2 = 1'b0, adj_dir2 = 1'b0;
    logic       sam_clk_en, sym_clk_en, frame_clk_en, adj_busy;
    logic [2:0] sam_phase;
    logic [3:0] sym_index;
    logic       s2_sam, s2_sym, s2_frm, s2_busy;
    logic [1:0] s2_ph;
    logic [0:0] s2_idx;
    int         cyc;
    int         errors = 0;
    int         checks = 0;
    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       e1, a1, e2, a2;

    clk_en_gen dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .run          (run),
        .sync         (sync),
        .adj_valid    (adj_valid),
        .adj_dir      (adj_dir),
        .sam_clk_en   (sam_clk_en),
        .sym_clk_en   (sym_clk_en),
        .frame_clk_en (frame_clk_en),
        .sam_phase    (sam_phase),
        .sym_index    (sym_index),
        .adj_busy     (adj_busy)
    );

    clk_en_gen #(.SAM_DIV(2), .SPS(2), .FRAME_LEN(1)) dut2 (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .run          (run2),
        .sync         (sync2),
        .adj_valid    (adj_valid2),
        .adj_dir      (adj_dir2),
        .sam_clk_en   (s2_sam),
        .sym_clk_en   (s2_sym),
        .frame_clk_en (s2_frm),
        .sam_phase    (s2_ph),
        .sym_index    (s2_idx),
        .adj_busy     (s2_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Cycle number = rising edges since reset release.
    always @(posedge sys_clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    // Monitor for the default instance: every sample strobe must match the head of the queue.
    always @(negedge sys_clk) begin
        if (reset && sam_clk_en) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected_strobe cycle=%0d phase=%0d index=%0d", cyc, sam_phase, sym_index);
            end else begin
                e1 = q1.pop_front();
                a1.c = cyc; a1.sym = sym_clk_en; a1.frm = frame_clk_en; a1.ph = sam_phase; a1.idx = sym_index;
                if (a1 !== e1) begin
                    errors++;
                    $display("FAIL dut1_strobe got cyc=%0d sym=%0b frm=%0b ph=%0d idx=%0d expected cyc=%0d sym=%0b frm=%0b ph=%0d idx=%0d",
                             a1.c, a1.sym, a1.frm, a1.ph, a1.idx, e1.c, e1.sym, e1.frm, e1.ph, e1.idx);
                end
            end
        end
    end

    // Monitor for the minimum-parameter instance.
    always @(negedge sys_clk) begin
        if (reset && s2_sam) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected_strobe cycle=%0d phase=%0d", cyc, s2_ph);
            end else begin
                e2 = q2.pop_front();
                a2.c = cyc; a2.sym = s2_sym; a2.frm = s2_frm; a2.ph = {1'b0, s2_ph}; a2.idx = {3'b0, s2_idx};
                if (a2 !== e2) begin
                    errors++;
                    $display("FAIL dut2_strobe got cyc=%0d sym=%0b frm=%0b ph=%0d idx=%0d expected cyc=%0d sym=%0b frm=%0b ph=%0d idx=%0d",
                             a2.c, a2.sym, a2.frm, a2.ph, a2.idx, e2.c, e2.sym, e2.frm, e2.ph, e2.idx);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic push(input bit second, input int c, input bit sym, input bit frm, input int ph, input int idx);
        exp_t e;
        e.c = c; e.sym = sym; e.frm = frm; e.ph = 3'(ph); e.idx = 4'(idx);
        if (second) q2.push_back(e);
        else q1.push_back(e);
    endtask

    // Advance to the falling edge that follows rising edge n.
    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 2000) begin
            @(negedge sys_clk);
            g++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc got=%0d expected=%0d", cyc, n);
        end
    endtask

    // Assert reset mid-run, check every output clears at once, then release on a falling edge.
    task automatic do_reset(input string tag);
        chk({tag, "_q1_drained"}, q1.size(), 0);
        chk({tag, "_q2_drained"}, q2.size(), 0);
        #1 reset = 1'b0;
        #1;
        chk({tag, "_rst_dut1"}, {sam_clk_en, sym_clk_en, frame_clk_en, sam_phase, sym_index, adj_busy}, 0);
        chk({tag, "_rst_dut2"}, {s2_sam, s2_sym, s2_frm, s2_ph, s2_idx, s2_busy}, 0);
        repeat (2) @(negedge sys_clk);
        reset = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge sys_clk);
        chk("reset_hold_dut1", {sam_clk_en, sym_clk_en, frame_clk_en, sam_phase, sym_index, adj_busy}, 0);

        // Defaults: strobe every 4, symbol every 16, frame every 256.
        run = 1'b1;
        reset = 1'b1;
        for (int k = 0; k <= 64; k++) push(0, 4 + 4 * k, k % 4 == 0, k % 64 == 0, k % 4, (k / 4) % 16);
        wait_cyc(262);

        // Advance at cycle 10: symbol from 20 has phases 0..2, next boundary at 32.
        do_reset("adv");
        push(0, 4, 1, 1, 0, 0); push(0, 8, 0, 0, 1, 0); push(0, 12, 0, 0, 2, 0); push(0, 16, 0, 0, 3, 0);
        push(0, 20, 1, 0, 0, 1); push(0, 24, 0, 0, 1, 1); push(0, 28, 0, 0, 2, 1);
        push(0, 32, 1, 0, 0, 2); push(0, 36, 0, 0, 1, 2); push(0, 40, 0, 0, 2, 2); push(0, 44, 0, 0, 3, 2);
        push(0, 48, 1, 0, 0, 3);
        wait_cyc(9);
        chk("adv_idle_busy", adj_busy, 0);
        adj_valid = 1'b1; adj_dir = 1'b1;
        wait_cyc(10);
        adj_valid = 1'b0;
        chk("adv_busy_set", adj_busy, 1);
        wait_cyc(31);
        chk("adv_busy_hold", adj_busy, 1);
        wait_cyc(32);
        chk("adv_busy_clear", adj_busy, 0);
        wait_cyc(50);

        // Retard at cycle 10: phases 0..4 over 20 cycles; a second request at 26 is ignored.
        do_reset("ret");
        push(0, 4, 1, 1, 0, 0); push(0, 8, 0, 0, 1, 0); push(0, 12, 0, 0, 2, 0); push(0, 16, 0, 0, 3, 0);
        push(0, 20, 1, 0, 0, 1); push(0, 24, 0, 0, 1, 1); push(0, 28, 0, 0, 2, 1); push(0, 32, 0, 0, 3, 1);
        push(0, 36, 0, 0, 4, 1); push(0, 40, 1, 0, 0, 2); push(0, 44, 0, 0, 1, 2); push(0, 48, 0, 0, 2, 2);
        push(0, 52, 0, 0, 3, 2); push(0, 56, 1, 0, 0, 3); push(0, 60, 0, 0, 1, 3);
        wait_cyc(9);
        adj_valid = 1'b1; adj_dir = 1'b0;
        wait_cyc(10);
        adj_valid = 1'b0;
        chk("ret_busy_set", adj_busy, 1);
        wait_cyc(25);
        adj_valid = 1'b1; adj_dir = 1'b1;
        wait_cyc(26);
        adj_valid = 1'b0;
        wait_cyc(39);
        chk("ret_busy_hold", adj_busy, 1);
        wait_cyc(40);
        chk("ret_busy_clear", adj_busy, 0);
        wait_cyc(62);
        chk("ret_busy_idle", adj_busy, 0);

        // Sync at 126 with phase 2 / index 7 and an adjust pending.
        do_reset("sync");
        for (int k = 0; k <= 30; k++) push(0, 4 + 4 * k, k % 4 == 0, k == 0, k % 4, k / 4);
        push(0, 126, 1, 1, 0, 0); push(0, 130, 0, 0, 1, 0); push(0, 134, 0, 0, 2, 0); push(0, 138, 0, 0, 3, 0);
        push(0, 142, 1, 0, 0, 1);
        wait_cyc(117);
        adj_valid = 1'b1; adj_dir = 1'b1;
        wait_cyc(118);
        adj_valid = 1'b0;
        chk("sync_pre_busy", adj_busy, 1);
        wait_cyc(125);
        chk("sync_pre_phase", sam_phase, 2);
        chk("sync_pre_index", sym_index, 7);
        sync = 1'b1;
        wait_cyc(126);
        sync = 1'b0;
        chk("sync_busy_drop", adj_busy, 0);
        wait_cyc(144);

        // run=0 for edges 22..30: counters frozen, divider resumes where it stopped.
        do_reset("run");
        push(0, 4, 1, 1, 0, 0); push(0, 8, 0, 0, 1, 0); push(0, 12, 0, 0, 2, 0); push(0, 16, 0, 0, 3, 0);
        push(0, 20, 1, 0, 0, 1); push(0, 33, 0, 0, 1, 1); push(0, 37, 0, 0, 2, 1); push(0, 41, 0, 0, 3, 1);
        push(0, 45, 1, 0, 0, 2); push(0, 49, 0, 0, 1, 2);
        wait_cyc(21);
        run = 1'b0;
        wait_cyc(26);
        chk("run_frozen_phase", sam_phase, 0);
        chk("run_frozen_index", sym_index, 1);
        wait_cyc(30);
        run = 1'b1;
        wait_cyc(51);

        // Minimum parameters: strobe every 2, symbol+frame every other strobe, advance gives 1-sample symbol.
        run = 1'b0;
        do_reset("min");
        run2 = 1'b1;
        push(1, 2, 1, 1, 0, 0); push(1, 4, 0, 0, 1, 0); push(1, 6, 1, 1, 0, 0); push(1, 8, 1, 1, 0, 0);
        push(1, 10, 0, 0, 1, 0); push(1, 12, 1, 1, 0, 0); push(1, 14, 0, 0, 1, 0);
        wait_cyc(4);
        adj_valid2 = 1'b1; adj_dir2 = 1'b1;
        wait_cyc(5);
        adj_valid2 = 1'b0;
        chk("min_busy_set", s2_busy, 1);
        wait_cyc(7);
        chk("min_busy_hold", s2_busy, 1);
        wait_cyc(8);
        chk("min_busy_clear", s2_busy, 0);
        wait_cyc(14);
        #1 reset = 1'b0;
        #1;
        chk("min_async_reset", {s2_sam, s2_sym, s2_frm, s2_ph, s2_idx, s2_busy}, 0);
        chk("min_q2_drained", q2.size(), 0);
        chk("min_q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
